// File: rtl/seq_det_pkg.sv
// Shared constants for the serial sequence detector.
//   DEF_PAT_W   : default pattern length in bits
//   DEF_CNT_W   : default match counter width in bits
//   RST_PATTERN : pattern loaded at reset (all zeros with LSB set), widest legal size;
//                 users take the low PAT_W bits.
package seq_det_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    localparam logic [15:0] RST_PATTERN = 16'h0001;

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating event counter with synchronous clear.
//   clk   : rising-edge clock
//   rstn  : synchronous active-low reset
//   inc   : count one event this cycle
//   clr   : clear the count; wins over inc
//   count : current count, sticks at all-ones
//   sat   : high while count is all-ones
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    assign sat = &count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with overlapping / non-overlapping modes.
//   clk         : rising-edge clock
//   rstn        : synchronous active-low reset
//   in_valid    : qualifies in_bit for this cycle
//   in_bit      : serial data bit
//   cfg_load    : load pattern/mode and flush history (drops any bit this cycle)
//   cfg_pattern : target sequence, MSB is the first bit received
//   cfg_overlap : 1 = overlapping detection, 0 = non-overlapping
//   cnt_clr     : clear the match counter
//   match       : one-cycle pulse in the cycle after a matching bit is accepted
//   match_cnt   : saturating count of matches
//   cnt_sat     : high while match_cnt is all-ones
//   fill        : number of valid history bits (0..PAT_W)
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    localparam int FW = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [FW-1:0]    fill
);

    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] pat_r;
    logic             ovl_r;
    logic [PAT_W-1:0] hist;

    logic             accept;
    logic [PAT_W-1:0] hist_next;
    logic [FW-1:0]    fill_next;
    logic             hit;

    // A configuration load takes the cycle; any bit presented with it is dropped.
    assign accept    = in_valid && !cfg_load;
    assign hist_next = {hist[PAT_W-2:0], in_bit};
    assign fill_next = (fill == FULL) ? FULL : fill + FW'(1);
    assign hit       = accept && (fill_next == FULL) && (hist_next == pat_r);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            match <= 1'b0;
            fill  <= '0;
            hist  <= '0;
            pat_r <= RST_PATTERN[PAT_W-1:0];
            ovl_r <= 1'b1;
        end else begin
            match <= hit;
            if (cfg_load) begin
                pat_r <= cfg_pattern;
                ovl_r <= cfg_overlap;
                fill  <= '0;
            end else if (accept) begin
                hist <= hist_next;
                // Non-overlapping mode restarts from an empty history after a match;
                // overlapping mode keeps it so a suffix can begin the next match.
                fill <= (hit && !ovl_r) ? '0 : fill_next;
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (hit),
        .clr  (cnt_clr),
        .count(match_cnt),
        .sat  (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector (PAT_W=4, CNT_W=8): table-driven
// stream vectors plus hand-written saturation and reset sequences.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic       in_bit;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       match;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic [2:0] fill;

    int checks   = 0;
    int failures = 0;

    seq_detector #(.PAT_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap),
        .cnt_clr    (cnt_clr),
        .match      (match),
        .match_cnt  (match_cnt),
        .cnt_sat    (cnt_sat),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       b;
        logic       ld;
        logic [3:0] pat;
        logic       ovl;
        logic       clr;
        logic       em;
        logic [2:0] ef;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic b, logic ld, logic [3:0] pat, logic ovl,
                                logic clr, logic em, logic [2:0] ef, logic [7:0] ec);
        vec_t r;
        r.v = v; r.b = b; r.ld = ld; r.pat = pat; r.ovl = ovl; r.clr = clr;
        r.em = em; r.ef = ef; r.ec = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle just after the rising edge.
    task automatic drive(input logic v, input logic b, input logic ld, input logic [3:0] pat,
                         input logic ovl, input logic clr);
        in_valid    = v;
        in_bit      = b;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        cnt_clr     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b, input logic clr);
        drive(1'b1, b, 1'b0, 4'b0000, 1'b0, clr);
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 4'b0000; cfg_overlap = 1'b0; cnt_clr = 1'b0;

        // Reset state
        drive(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
        chk("reset_match", match, 0);
        chk("reset_cnt", match_cnt, 0);
        chk("reset_fill", fill, 0);
        chk("reset_sat", cnt_sat, 0);
        rstn = 1'b1;

        // Overlap mode, stream 1,0,1,1,0,1,1
        tbl.push_back(mk(0,0,1,4'b1011,1,0, 0,0,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,1,0));
        tbl.push_back(mk(1,0,0,4'b0000,0,0, 0,2,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,3,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 1,4,1));
        tbl.push_back(mk(1,0,0,4'b0000,0,0, 0,4,1));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,4,1));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 1,4,2));
        // Non-overlap mode, same stream
        tbl.push_back(mk(0,0,1,4'b1011,0,1, 0,0,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,1,0));
        tbl.push_back(mk(1,0,0,4'b0000,0,0, 0,2,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,3,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 1,0,1));
        tbl.push_back(mk(1,0,0,4'b0000,0,0, 0,1,1));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,2,1));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,3,1));
        // Gap of invalid cycles in the middle of a match
        tbl.push_back(mk(0,0,1,4'b1011,1,1, 0,0,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,1,0));
        tbl.push_back(mk(1,0,0,4'b0000,0,0, 0,2,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,3,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,1,0,4'b0000,0,0, 0,3,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 1,4,1));
        // cfg_load beats a coincident valid bit
        tbl.push_back(mk(0,0,1,4'b1011,1,1, 0,0,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,1,0));
        tbl.push_back(mk(1,0,0,4'b0000,0,0, 0,2,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,3,0));
        tbl.push_back(mk(1,1,1,4'b1011,1,0, 0,0,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,1,0));
        tbl.push_back(mk(1,0,0,4'b0000,0,0, 0,2,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 0,3,0));
        tbl.push_back(mk(1,1,0,4'b0000,0,0, 1,4,1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].b, tbl[i].ld, tbl[i].pat, tbl[i].ovl, tbl[i].clr);
            chk($sformatf("vec%0d_match", i), match, tbl[i].em);
            chk($sformatf("vec%0d_fill", i), fill, tbl[i].ef);
            chk($sformatf("vec%0d_cnt", i), match_cnt, tbl[i].ec);
        end

        // Saturation: pattern 1111 overlapping matches on every 1 once primed
        drive(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) bit_in(1'b1, 1'b0);
        chk("sat_prime_match", match, 0);
        for (int i = 0; i < 255; i++) bit_in(1'b1, 1'b0);
        chk("sat_255_match", match, 1);
        chk("sat_255_cnt", match_cnt, 255);
        chk("sat_255_flag", cnt_sat, 1);
        bit_in(1'b1, 1'b0);
        chk("sat_hold_match", match, 1);
        chk("sat_hold_cnt", match_cnt, 255);
        chk("sat_hold_flag", cnt_sat, 1);
        bit_in(1'b1, 1'b1);
        chk("clr_vs_match_pulse", match, 1);
        chk("clr_vs_match_cnt", match_cnt, 0);
        chk("clr_vs_match_sat", cnt_sat, 0);
        bit_in(1'b0, 1'b0);
        chk("after_clr_match", match, 0);

        // Reset mid-sequence: the bit on the reset edge would otherwise match
        drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b1, 1'b0);
        chk("pre_rst_cnt", match_cnt, 1);
        bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        rstn = 1'b0;
        bit_in(1'b1, 1'b0);
        chk("rst_mid_match", match, 0);
        chk("rst_mid_cnt", match_cnt, 0);
        chk("rst_mid_fill", fill, 0);
        rstn = 1'b1;
        bit_in(1'b1, 1'b0);
        chk("post_rst_match", match, 0);
        chk("post_rst_fill", fill, 1);
        // Reset pattern 0001: history now 0001 with one bit; 0,0,0,1 completes it
        bit_in(1'b0, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b0, 1'b0);
        chk("rstpat_partial_match", match, 0);
        chk("rstpat_partial_fill", fill, 4);
        bit_in(1'b1, 1'b0);
        chk("rstpat_match", match, 1);
        chk("rstpat_cnt", match_cnt, 1);
        chk("rstpat_fill_kept", fill, 4);
        drive(1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        chk("idle_match", match, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
